// File: rtl/radix_4_quo_accum.sv
// radix_4_quo_accum: radix-4 quotient digit decoder with on-the-fly Q/QM
// conversion for the SRT divider iteration loop.
// Optional build macro: RADIX_4_QUO_ACCUM_CHECK_EN enables the sticky
// illegal-sign-pattern flag on err_o; without it err_o is tied low.
module radix_4_quo_accum #(
  parameter  int unsigned QUO_W  = 64,
  localparam int unsigned ITER_W = $clog2(QUO_W/2 + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [ITER_W-1:0] iter_num_i,
  input  logic              iter_valid_i,
  input  logic              sd_m_neg_1_sign_i,
  input  logic              sd_m_neg_0_sign_i,
  input  logic              sd_m_pos_1_sign_i,
  input  logic              sd_m_pos_2_sign_i,
  input  logic              rem_sign_i,
  output logic [4:0]        digit_o,
  output logic              finish_valid_o,
  input  logic              finish_ready_i,
  output logic [QUO_W-1:0]  quo_o,
  output logic [QUO_W-1:0]  quo_m1_o,
  output logic [QUO_W-1:0]  quo_final_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e            state_q, state_d;
  logic [QUO_W-1:0]  q_q, q_d;
  logic [QUO_W-1:0]  qm_q, qm_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              rem_sign_q, rem_sign_d;

  logic [3:0] sign_c;
  logic [1:0] q_app_c, qm_app_c;
  logic       d_nonneg_c, d_pos_c;
  logic       start_hs_c, accept_c;

  assign sign_c = {sd_m_pos_2_sign_i, sd_m_pos_1_sign_i,
                   sd_m_neg_0_sign_i, sd_m_neg_1_sign_i};

  // Sign pattern to one-hot digit; 10 and the illegal 01 in [2:1] both give 0
  always_comb begin
    digit_o = 5'b00100;
    if (sign_c[2:1] == 2'b00) begin
      digit_o = sign_c[3] ? 5'b01000 : 5'b10000;
    end else if (sign_c[2:1] == 2'b11) begin
      digit_o = sign_c[0] ? 5'b00001 : 5'b00010;
    end
  end

  // Low digit pair appended to Q and QM for the decoded digit
  always_comb begin
    q_app_c  = 2'b00;
    qm_app_c = 2'b11;
    case (digit_o)
      5'b10000: begin q_app_c = 2'b10; qm_app_c = 2'b01; end
      5'b01000: begin q_app_c = 2'b01; qm_app_c = 2'b00; end
      5'b00010: begin q_app_c = 2'b11; qm_app_c = 2'b10; end
      5'b00001: begin q_app_c = 2'b10; qm_app_c = 2'b01; end
      default:  begin q_app_c = 2'b00; qm_app_c = 2'b11; end
    endcase
  end

  assign d_nonneg_c = ~(digit_o[0] | digit_o[1]);
  assign d_pos_c    = digit_o[3] | digit_o[4];
  assign start_hs_c = (state_q == IDLE) && start_valid_i;
  assign accept_c   = (state_q == ITER) && iter_valid_i;

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    qm_d       = qm_q;
    cnt_d      = cnt_q;
    rem_sign_d = rem_sign_q;
    case (state_q)
      IDLE: begin
        if (start_valid_i) begin
          state_d    = ITER;
          q_d        = '0;
          qm_d       = '1;
          cnt_d      = (iter_num_i == '0) ? ITER_W'(QUO_W/2) : iter_num_i;
          rem_sign_d = 1'b0;
        end
      end
      ITER: begin
        if (iter_valid_i) begin
          q_d   = d_nonneg_c ? {q_q[QUO_W-3:0], q_app_c}
                             : {qm_q[QUO_W-3:0], q_app_c};
          qm_d  = d_pos_c    ? {q_q[QUO_W-3:0], qm_app_c}
                             : {qm_q[QUO_W-3:0], qm_app_c};
          cnt_d = cnt_q - ITER_W'(1);
          if (cnt_q == ITER_W'(1)) begin
            state_d    = DONE;
            rem_sign_d = rem_sign_i;
          end
        end
      end
      DONE: begin
        if (finish_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Quotient, counter and remainder-sign registers
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      qm_q       <= '0;
      cnt_q      <= '0;
      rem_sign_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      qm_q       <= qm_d;
      cnt_q      <= cnt_d;
      rem_sign_q <= rem_sign_d;
    end
  end

`ifdef RADIX_4_QUO_ACCUM_CHECK_EN
  logic err_q, err_d;
  logic illegal_c;

  assign illegal_c = (sign_c[2:1] == 2'b01);

  // Sticky flag: set by an accepted illegal pattern, cleared by a new start
  always_comb begin
    err_d = err_q;
    if (start_hs_c) begin
      err_d = 1'b0;
    end else if (accept_c && illegal_c) begin
      err_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_hs_c;
  assign unused_hs_c = start_hs_c ^ accept_c;
  assign err_o       = 1'b0;
`endif

  assign start_ready_o  = (state_q == IDLE);
  assign finish_valid_o = (state_q == DONE);
  assign quo_o          = q_q;
  assign quo_m1_o       = qm_q;
  assign quo_final_o    = rem_sign_q ? qm_q : q_q;

endmodule

// File: tb/tb_radix_4_quo_accum.sv
// Self-checking bench for radix_4_quo_accum at QUO_W=8: directed test plan
// steps followed by randomized traffic, all checked against a value-level
// model (Q as an integer accumulating 4*Q+d, QM = Q-1).
module tb_radix_4_quo_accum;

  localparam int unsigned W    = 8;
  localparam int unsigned IW   = $clog2(W/2 + 1);
  localparam int          MASK = (1 << W) - 1;
`ifdef RADIX_4_QUO_ACCUM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [IW-1:0] iter_num;
  logic          iter_valid;
  logic          n1, n0, p1, p2;
  logic          rem_sign;
  logic [4:0]    digit;
  logic          finish_valid;
  logic          finish_ready;
  logic [W-1:0]  quo, quo_m1, quo_final;
  logic          err;

  radix_4_quo_accum #(.QUO_W(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_valid_i     (start_valid),
    .start_ready_o     (start_ready),
    .iter_num_i        (iter_num),
    .iter_valid_i      (iter_valid),
    .sd_m_neg_1_sign_i (n1),
    .sd_m_neg_0_sign_i (n0),
    .sd_m_pos_1_sign_i (p1),
    .sd_m_pos_2_sign_i (p2),
    .rem_sign_i        (rem_sign),
    .digit_o           (digit),
    .finish_valid_o    (finish_valid),
    .finish_ready_i    (finish_ready),
    .quo_o             (quo),
    .quo_m1_o          (quo_m1),
    .quo_final_o       (quo_final),
    .err_o             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: 0=idle, 1=iterating, 2=done
  int m_state = 0;
  int m_q     = 0;
  int m_qm    = 0;
  int m_cnt   = 0;
  bit m_rs    = 1'b0;
  bit m_err   = 1'b0;

  // Digit selected by the comparator signs s = {pos_2, pos_1, neg_0, neg_1}
  function automatic int dec(input logic [3:0] s);
    if (s[2] && s[1]) return s[0] ? -2 : -1;
    if (s[2] || s[1]) return 0;
    return s[3] ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_s(input logic [3:0] s);
    {p2, p1, n0, n1} = s;
  endtask

  // One clock with the currently driven inputs: check digit, advance model, check outputs
  task automatic cyc();
    logic [3:0] s;
    int d;
    #1;
    s = {p2, p1, n0, n1};
    d = dec(s);
    chk("digit", 32'(digit), 32'(1 << (d + 2)));
    if (rst) begin
      m_state = 0; m_q = 0; m_qm = 0; m_cnt = 0; m_rs = 1'b0; m_err = 1'b0;
    end else begin
      case (m_state)
        0: if (start_valid) begin
          m_state = 1; m_q = 0; m_qm = MASK; m_rs = 1'b0; m_err = 1'b0;
          m_cnt = (iter_num == 0) ? W/2 : int'(iter_num);
        end
        1: if (iter_valid) begin
          m_q  = (m_q * 4 + d) & MASK;
          m_qm = (m_q - 1) & MASK;
          if (CHK && !s[2] && s[1]) m_err = 1'b1;
          m_cnt--;
          if (m_cnt == 0) begin
            m_state = 2;
            m_rs    = rem_sign;
          end
        end
        default: if (finish_ready) m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
    chk("start_ready", 32'(start_ready), 32'(m_state == 0));
    chk("finish_valid", 32'(finish_valid), 32'(m_state == 2));
    chk("quo", 32'(quo), 32'(m_q));
    chk("quo_m1", 32'(quo_m1), 32'(m_qm));
    chk("quo_final", 32'(quo_final), 32'(m_rs ? m_qm : m_q));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic start(input int n);
    start_valid = 1'b1;
    iter_num    = IW'(n);
    cyc();
    start_valid = 1'b0;
  endtask

  task automatic dig(input logic [3:0] s, input bit rs);
    iter_valid = 1'b1;
    set_s(s);
    rem_sign = rs;
    cyc();
    iter_valid = 1'b0;
    rem_sign   = 1'b0;
  endtask

  task automatic finish();
    finish_ready = 1'b1;
    cyc();
    finish_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; iter_num = '0; iter_valid = 1'b0;
    rem_sign = 1'b0; finish_ready = 1'b0;
    set_s(4'b1100);
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_ready", 32'(start_ready), 32'h1);
    chk("rst_quo", 32'(quo), 32'h0);
    chk("rst_quo_m1", 32'(quo_m1), 32'h0);
    rst = 1'b0;

    // Four +2 digits
    start(4);
    repeat (3) dig(4'b0000, 1'b0);
    chk("t1_not_done", 32'(finish_valid), 32'h0);
    dig(4'b0000, 1'b0);
    chk("t1_done", 32'(finish_valid), 32'h1);
    chk("t1_quo", 32'(quo), 32'hAA);
    chk("t1_quo_m1", 32'(quo_m1), 32'hA9);
    finish();
    chk("t1_idle", 32'(start_ready), 32'h1);

    // Digits -1,0,0,0 with iter_num 0, negative remainder
    start(0);
    dig(4'b1110, 1'b0);
    repeat (2) dig(4'b1100, 1'b0);
    dig(4'b1100, 1'b1);
    chk("t2_quo", 32'(quo), 32'hC0);
    chk("t2_quo_m1", 32'(quo_m1), 32'hBF);
    chk("t2_final", 32'(quo_final), 32'hBF);
    // Back-pressure in DONE with spurious start and digit strobes
    start_valid = 1'b1;
    iter_valid  = 1'b1;
    set_s(4'b0000);
    repeat (5) cyc();
    chk("t2_hold_ready", 32'(start_ready), 32'h0);
    chk("t2_hold_quo", 32'(quo), 32'hC0);
    iter_valid = 1'b0;
    finish();
    chk("t2_no_same_cycle_start", 32'(start_ready), 32'h1);
    start_valid = 1'b0;
    iter_valid  = 1'b1;
    repeat (2) cyc();
    iter_valid = 1'b0;
    chk("t2_idle_iter_ignored", 32'(quo), 32'hC0);

    // Same digits with a three-cycle stall between digits 2 and 3
    start(0);
    dig(4'b1110, 1'b0);
    dig(4'b1100, 1'b0);
    set_s(4'b0000);
    repeat (3) cyc();
    dig(4'b1100, 1'b0);
    chk("t3_not_done", 32'(finish_valid), 32'h0);
    dig(4'b1100, 1'b1);
    chk("t3_done", 32'(finish_valid), 32'h1);
    chk("t3_final", 32'(quo_final), 32'hBF);
    finish();

    // Reset in the middle of a division, then +1,-2,+1,0
    start(4);
    repeat (2) dig(4'b0000, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t4_rst_quo", 32'(quo), 32'h0);
    chk("t4_rst_ready", 32'(start_ready), 32'h1);
    start(4);
    dig(4'b1000, 1'b0);
    dig(4'b1111, 1'b0);
    dig(4'b1000, 1'b0);
    dig(4'b1100, 1'b0);
    chk("t4_quo", 32'(quo), 32'h24);
    finish();

    // Illegal pattern at digit 2
    start(4);
    dig(4'b1100, 1'b0);
    set_s(4'b0010);
    #1;
    chk("t5_digit", 32'(digit), 32'h04);
    dig(4'b0010, 1'b0);
    chk("t5_err", 32'(err), 32'(CHK));
    repeat (2) dig(4'b1100, 1'b0);
    chk("t5_quo", 32'(quo), 32'h0);
    chk("t5_err_done", 32'(err), 32'(CHK));
    finish();
    start(4);
    chk("t5_err_clr", 32'(err), 32'h0);
    repeat (4) dig(4'b1000, 1'b0);
    finish();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst          = ($urandom_range(63) == 0);
      start_valid  = 1'($urandom_range(1));
      iter_num     = IW'($urandom_range(W/2));
      iter_valid   = ($urandom_range(3) != 0);
      set_s(4'($urandom_range(15)));
      rem_sign     = 1'($urandom_range(1));
      finish_ready = 1'($urandom_range(1));
      cyc();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
